// File: rtl/img_sram_rx_tx.sv
// Image frame buffer: a DEPTH x 8 single-port SRAM loaded in raster order from a
// byte stream (rx) and streamed back out in the same order (tx).
module img_sram_rx_tx #(
  parameter int DEPTH  = 16384,
  parameter int MAXDIM = 128
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] nrows,
  input  logic [7:0] ncols,
  input  logic       rx_en,
  input  logic [7:0] din,
  output logic       rx_busy,
  input  logic       tx_en,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       tx_busy
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [7:0] MAX_B = 8'(MAXDIM);

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_LOAD = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_READ  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_t;

  rx_state_t     r_rx_state;
  tx_state_t     r_tx_state;
  logic [AW-1:0] r_rx_addr;
  logic [AW-1:0] r_rx_last;
  logic [AW-1:0] r_tx_addr;
  logic [AW-1:0] r_tx_last;
  logic [7:0]    r_rx_data;
  logic [7:0]    r_rdata;
  logic [7:0]    r_dout;
  logic          r_rd_vld;
  logic          r_dout_valid;
  logic [7:0]    r_mem [DEPTH];

  logic [7:0]    w_rows;
  logic [7:0]    w_cols;
  logic [15:0]   w_npix;
  logic [AW-1:0] w_last;
  logic [AW-1:0] w_addr;
  logic          w_dims_ok;
  logic          w_idle;
  logic          w_rx_start;
  logic          w_tx_start;

  // Frame geometry, clamped to MAXDIM; only sampled on an accepted start edge.
  assign w_rows    = (nrows > MAX_B) ? MAX_B : nrows;
  assign w_cols    = (ncols > MAX_B) ? MAX_B : ncols;
  assign w_npix    = {8'h00, w_rows} * {8'h00, w_cols};
  assign w_last    = AW'(w_npix - 16'd1);
  assign w_dims_ok = (nrows != 8'd0) && (ncols != 8'd0);

  // Start pulses are accepted only with both sides idle; rx wins a tie and the
  // tx pulse is dropped. dout_valid marks a one-cycle pixel beat with no
  // backpressure; dout keeps its last value while dout_valid is low.
  assign rx_busy    = (r_rx_state == RX_LOAD);
  assign tx_busy    = (r_tx_state != TX_IDLE);
  assign w_idle     = !rx_busy && !tx_busy;
  assign w_rx_start = w_idle && rx_en && w_dims_ok;
  assign w_tx_start = w_idle && tx_en && !rx_en && w_dims_ok;

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  // rx owns the single SRAM port for the whole load; tx reads otherwise.
  assign w_addr = rx_busy ? r_rx_addr : r_tx_addr;

  always_ff @(posedge clk) begin
    if (rx_busy) begin
      r_mem[w_addr] <= r_rx_data;
    end else begin
      r_rdata <= r_mem[w_addr];
    end
  end

  // Receive: din is captured on each edge and written one edge later, so the
  // final pixel lands on the edge where rx_busy drops.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_rx_state <= RX_IDLE;
      r_rx_addr  <= '0;
      r_rx_last  <= '0;
      r_rx_data  <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_start) begin
            r_rx_state <= RX_LOAD;
            r_rx_addr  <= '0;
            r_rx_last  <= w_last;
            r_rx_data  <= din;
          end
        end
        RX_LOAD: begin
          r_rx_data <= din;
          if (r_rx_addr == r_rx_last) begin
            r_rx_state <= RX_IDLE;
            r_rx_addr  <= '0;
          end else begin
            r_rx_addr <= r_rx_addr + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmit: one read per cycle in READ, then DRAIN until the two-stage
  // read/output pipeline has emptied.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_tx_state   <= TX_IDLE;
      r_tx_addr    <= '0;
      r_tx_last    <= '0;
      r_rd_vld     <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= 8'h00;
    end else begin
      r_rd_vld     <= (r_tx_state == TX_READ);
      r_dout_valid <= r_rd_vld;
      if (r_rd_vld) begin
        r_dout <= r_rdata;
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_start) begin
            r_tx_state <= TX_READ;
            r_tx_addr  <= '0;
            r_tx_last  <= w_last;
          end
        end
        TX_READ: begin
          if (r_tx_addr == r_tx_last) begin
            r_tx_state <= TX_DRAIN;
            r_tx_addr  <= '0;
          end else begin
            r_tx_addr <= r_tx_addr + 1'b1;
          end
        end
        TX_DRAIN: begin
          if (!r_rd_vld) begin
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_sram_rx_tx.sv
// Bench for img_sram_rx_tx: random frames loaded and unloaded against an array
// model of the frame store, with cycle-exact busy/valid expectations.
module tb_img_sram_rx_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic       rx_en;
  logic [7:0] din;
  logic       rx_busy;
  logic       tx_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       tx_busy;

  logic [7:0] model_mem [16384];
  logic [7:0] ld_q[$];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  img_sram_rx_tx #(.DEPTH(16384), .MAXDIM(128)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .nrows      (nrows),
    .ncols      (ncols),
    .rx_en      (rx_en),
    .din        (din),
    .rx_busy    (rx_busy),
    .tx_en      (tx_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .tx_busy    (tx_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampd(input int v);
    return (v > 128) ? 128 : v;
  endfunction

  task automatic fill_random(input int n);
    ld_q.delete();
    for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom));
  endtask

  task automatic fill_ramp(input int base, input int n);
    ld_q.delete();
    for (int i = 0; i < n; i++) ld_q.push_back(8'(base + i));
  endtask

  // Load ld_q as an r x c frame. Entered and left on a falling edge.
  // tx_at: -1 none, 0 tx_en together with rx_en, k>0 tx_en before pixel k's edge.
  task automatic do_load(input int r, input int c, input int tx_at);
    int n, cyc, tx_seen;
    n = clampd(r) * clampd(c);
    nrows = 8'(r);
    ncols = 8'(c);
    rx_en = 1'b1;
    tx_en = (tx_at == 0);
    din   = ld_q[0];
    cyc = 0;
    tx_seen = 0;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      rx_en = 1'b0;
      tx_en = (k == tx_at);
      din   = (k < n) ? ld_q[k] : 8'($urandom);
      if (rx_busy === 1'b1) cyc++;
      if (dout_valid !== 1'b0 || tx_busy !== 1'b0) tx_seen++;
    end
    tx_en = 1'b0;
    for (int k = 0; k < n; k++) model_mem[k] = ld_q[k];
    n_vec++;
    if (cyc != n) begin
      n_err++;
      $display("FAIL load_busy_cycles %0dx%0d: got %0d cycles, exp %0d", r, c, cyc, n);
    end
    n_vec++;
    if (tx_seen != 0) begin
      n_err++;
      $display("FAIL load_tx_quiet %0dx%0d: got %0d tx-active cycles, exp 0", r, c, tx_seen);
    end
  endtask

  // Unload an r x c frame and check it against the model.
  // rx_at: -1 none, else cycle index (0..N+1) at which rx_en is pulsed.
  task automatic do_unload(input int r, input int c, input int rx_at);
    int n, rx_seen;
    logic exp_valid, exp_busy;
    logic [7:0] e;
    n = clampd(r) * clampd(c);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model_mem[k]);
    nrows = 8'(r);
    ncols = 8'(c);
    tx_en = 1'b1;
    rx_en = 1'b0;
    rx_seen = 0;
    for (int j = 0; j <= n + 2; j++) begin
      @(negedge clk);
      tx_en = 1'b0;
      rx_en = (j == rx_at);
      din   = 8'($urandom);
      if (rx_busy !== 1'b0) rx_seen++;
      exp_valid = (j >= 2) && (j <= n + 1);
      exp_busy  = (j <= n + 1);
      n_vec++;
      if (dout_valid !== exp_valid) begin
        n_err++;
        $display("FAIL unload_valid %0dx%0d cyc %0d: got %b exp %b", r, c, j, dout_valid, exp_valid);
      end
      n_vec++;
      if (tx_busy !== exp_busy) begin
        n_err++;
        $display("FAIL unload_busy %0dx%0d cyc %0d: got %b exp %b", r, c, j, tx_busy, exp_busy);
      end
      if (dout_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unload_extra %0dx%0d cyc %0d: got %02h exp no pixel", r, c, j, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_err++;
            $display("FAIL unload_data %0dx%0d cyc %0d: got %02h exp %02h", r, c, j, dout, e);
          end
        end
      end
    end
    rx_en = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL unload_count %0dx%0d: got %0d pixels left, exp 0", r, c, exp_q.size());
    end
    n_vec++;
    if (dout !== model_mem[n-1]) begin
      n_err++;
      $display("FAIL dout_hold %0dx%0d: got %02h exp %02h", r, c, dout, model_mem[n-1]);
    end
    n_vec++;
    if (rx_seen != 0) begin
      n_err++;
      $display("FAIL unload_rx_quiet %0dx%0d: got %0d rx-busy cycles, exp 0", r, c, rx_seen);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_dout);
    n_vec++;
    if (rx_busy !== 1'b0) begin n_err++; $display("FAIL %s rx_busy: got %b exp 0", tag, rx_busy); end
    n_vec++;
    if (tx_busy !== 1'b0) begin n_err++; $display("FAIL %s tx_busy: got %b exp 0", tag, tx_busy); end
    n_vec++;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL %s dout_valid: got %b exp 0", tag, dout_valid); end
    n_vec++;
    if (dout !== exp_dout) begin n_err++; $display("FAIL %s dout: got %02h exp %02h", tag, dout, exp_dout); end
  endtask

  task automatic test_reset();
    rx_en = 1'b0;
    tx_en = 1'b0;
    din   = 8'h00;
    nrows = 8'd0;
    ncols = 8'd0;
    rstn  = 1'b0;
    #2 rstn = 1'b1;
    #1 check_idle_outputs("reset_async", 8'h00);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_release", 8'h00);
  endtask

  task automatic test_small_frame();
    fill_ramp(8'h10, 15);
    do_load(3, 5, -1);
    do_unload(3, 5, -1);
  endtask

  task automatic test_full_frame();
    fill_random(16384);
    do_load(128, 128, -1);
    do_unload(128, 128, -1);
  endtask

  task automatic test_arbitration();
    fill_random(24);
    do_load(4, 6, int'($urandom_range(23, 1)));
    do_unload(4, 6, int'($urandom_range(25, 0)));
    do_unload(4, 6, -1);
    fill_random(12);
    do_load(3, 4, 0);
    do_unload(3, 4, -1);
  endtask

  task automatic test_reset_mid_load();
    nrows = 8'd128;
    ncols = 8'd128;
    rx_en = 1'b1;
    din   = 8'($urandom);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      rx_en = 1'b0;
      din   = 8'($urandom);
    end
    n_vec++;
    if (rx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midload_busy: got %b exp 1", rx_busy);
    end
    rstn = 1'b1;
    #1 check_idle_outputs("midload_reset", 8'h00);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("midload_after", 8'h00);
    fill_ramp(8'hA1, 4);
    do_load(2, 2, -1);
    do_unload(2, 2, -1);
  endtask

  task automatic test_boundaries();
    nrows = 8'd0;
    ncols = 8'd7;
    rx_en = 1'b1;
    @(negedge clk);
    rx_en = 1'b0;
    nrows = 8'd5;
    ncols = 8'd0;
    tx_en = 1'b1;
    @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    check_idle_outputs("zero_dim_start", model_mem[3]);
    fill_random(128);
    do_load(200, 1, -1);
    do_unload(200, 1, -1);
    fill_random(1);
    do_load(1, 1, -1);
    do_unload(1, 1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      int r, c;
      r = int'($urandom_range(9, 1));
      c = int'($urandom_range(9, 1));
      fill_random(r * c);
      do_load(r, c, -1);
      do_unload(r, c, -1);
    end
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_full_frame();
    test_arbitration();
    test_reset_mid_load();
    test_boundaries();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img_sram_rx_tx.md
# img_sram_rx_tx

Image frame buffer with byte-stream load and unload. It wraps a 16384×8 single-port image SRAM (img_sram), a receive controller (io_rx_controller) and a transmit controller (io_tx_controller). The receive controller writes a raster-order pixel stream into the SRAM, and the transmit controller streams it back out in the same order. It sits between the chip byte I/O and the convolution engine's image store.

## Interface
Parameters:
- DEPTH, 16384: SRAM words; address width is $clog2(DEPTH) = 14.
- MAXDIM, 128: maximum rows and maximum columns.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rstn  in  1  reset; asynchronous, active-high (1 = reset), despite the legacy name.
- nrows  in  8  image rows; legal values 1..MAXDIM.
- ncols  in  8  image columns; legal values 1..MAXDIM.
- rx_en  in  1  one-cycle start pulse for a load.
- din  in  8  load pixel stream.
- rx_busy  out  1  load in progress.
- tx_en  in  1  one-cycle start pulse for an unload.
- dout  out  8  unload pixel stream.
- dout_valid  out  1  dout holds a valid pixel this cycle.
- tx_busy  out  1  unload in progress.

## Operation
- N = nrows*ncols, latched at the start edge.
- nrows/ncols values above MAXDIM clamp to MAXDIM.
- A start with nrows=0 or ncols=0 is ignored; busy stays 0.
- SRAM:
  - single port, synchronous write, synchronous read with 1-cycle latency.
  - contents are not cleared by reset.
- Addressing: linear address = row*ncols + col, raster order, 0..N-1.
- Port ownership: the SRAM port is driven by rx while rx_busy=1, otherwise by tx.
- Receive FSM, IDLE -> LOAD -> IDLE:
  - rx_en=1 in IDLE starts the load.
  - Address counter increments by 1 per pixel.
  - Returns to IDLE after pixel N-1 is written.
- Transmit FSM, IDLE -> READ -> DRAIN -> IDLE:
  - Issues reads at addresses 0..N-1, one per cycle.
  - Registers the SRAM output onto dout.
- Arbitration:
  - rx_en is ignored while rx_busy or tx_busy.
  - tx_en is ignored while rx_busy or tx_busy.
  - rx_en and tx_en on the same idle edge: the load starts, tx_en is dropped.
- dout holds its last value when dout_valid=0.
- Reset, including mid-operation: both FSMs go to IDLE, counters clear, and any transfer in progress is aborted with no completion.
- Reset values: rx_busy=0, tx_busy=0, dout_valid=0, dout=8'h00.

## Timing
- Load; E0 = edge sampling rx_en=1 in IDLE:
  - din at E0 is pixel 0; din at edge E0+k is pixel k, one pixel every cycle, no stalls.
  - rx_busy=1 from E0; falls at edge E0+N.
  - All N pixels are readable from the cycle rx_busy falls.
- Unload; E0 = edge sampling tx_en=1 in IDLE:
  - tx_busy=1 from E0.
  - Read of address k is issued in the cycle after E0+k.
  - Pixel k appears on dout with dout_valid=1 after edge E0+2+k, for exactly one cycle.
  - After the last pixel, dout_valid and tx_busy fall together at edge E0+N+2.
- Back-to-back: a new start is accepted on the first edge with both busy flags 0, so a load followed by an unload needs at least 1 idle cycle.
- Latency summary: load 1 pixel/cycle with zero turnaround; unload first pixel 2 cycles after start, then 1 pixel/cycle.

## Test plan
- Full frame: nrows=ncols=128, load 16384 bytes of a known image file, then unload.
  - dout sequence equals input byte-for-byte.
  - rx_busy high for 16384 cycles.
  - dout_valid high for 16384 consecutive cycles starting 2 cycles after the tx_en edge.
- Small frame: nrows=3, ncols=5, load bytes 0x10..0x1E, then unload.
  - 15 valid outputs 0x10..0x1E.
  - tx_busy falls at E0+17.
- Arbitration:
  - tx_en pulsed mid-load: ignored, no dout_valid.
  - rx_en pulsed mid-unload: ignored, SRAM unchanged.
  - Simultaneous rx_en and tx_en: the load runs, no unload.
- Reset mid-load after 100 bytes: outputs go to reset values immediately, not at the next edge. A subsequent 2x2 load/unload of 0xA1..0xA4 returns 0xA1..0xA4.
- Boundaries:
  - nrows=0 start: ignored.
  - nrows=200, ncols=1: clamps to 128×1 and loads 128 bytes.
  - nrows=ncols=1: single byte round-trip, rx_busy high 1 cycle.
